// File: rtl/tx_nibble_buffer.sv
// tx_nibble_buffer: transmit-side source stage for the 4-bit receiver.
//
// A local producer pushes words into a small circular FIFO. A single output
// register then presents them to the receiver over a valid/ready handshake.
// The word is held stable under back-pressure, and words stream back-to-back
// at one per cycle while the receiver is ready. Completed transfers are
// counted, and a sticky flag records any write dropped because the FIFO was
// full.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   wr_en_i     in   producer write strobe
//   wr_data_i   in   producer data
//   full_o      out  FIFO holds DEPTH words (from registered count)
//   ready_i     in   receiver ready
//   valid_o     out  data_o holds a word to transfer (registered)
//   data_o      out  registered output word
//   empty_o     out  FIFO empty and no word held in data_o
//   sent_cnt_o  out  completed transfers, modulo 2^CNT_W
//   overflow_o  out  sticky, set when a write is dropped
module tx_nibble_buffer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              full_o,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  sent_cnt_o,
    output logic              overflow_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic xfer;

    // Status is decoded from registered count only, so a pop on the same edge
    // never makes room for a write.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign push       = wr_en_i && !fifo_full;
    assign xfer       = (state_q == StHold) && ready_i;

    // Output register FSM: loads the FIFO head whenever the slot is free or
    // is being vacated by a transfer in this cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ready_i) begin
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        data_d = mem_q[rd_ptr_q];
                    end else begin
                        // data_q keeps the last word; valid_o drops.
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        sent_cnt_d = xfer ? sent_cnt_q + CNT_W'(1) : sent_cnt_q;
        overflow_d = overflow_q || (wr_en_i && fifo_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            data_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            sent_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            sent_cnt_q <= sent_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: only entries behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign full_o     = fifo_full;
    assign valid_o    = (state_q == StHold);
    assign data_o     = data_q;
    assign empty_o    = fifo_empty && (state_q == StIdle);
    assign sent_cnt_o = sent_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_tx_nibble_buffer.sv
// Testbench for tx_nibble_buffer: directed stimulus, a queue-based reference
// model checked against the DUT on every cycle, plus literal expectations.
module tb_tx_nibble_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       ready = 1'b0;
    logic       full_o;
    logic       valid_o;
    logic [3:0] data_o;
    logic       empty_o;
    logic [7:0] sent_cnt_o;
    logic       overflow_o;

    int checks = 0;
    int failures = 0;

    tx_nibble_buffer #(
        .DATA_W(4),
        .DEPTH (DEPTH),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .full_o    (full_o),
        .ready_i   (ready),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .empty_o   (empty_o),
        .sent_cnt_o(sent_cnt_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue plus the presented word.
    logic [3:0] m_q[$];
    logic       m_valid = 1'b0;
    logic [3:0] m_data = 4'h0;
    logic [7:0] m_cnt = 8'h0;
    logic       m_ovf = 1'b0;
    bit         started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit was_full;
        bit xfer;
        if (rst) begin
            m_q.delete();
            m_valid = 1'b0;
            m_data  = 4'h0;
            m_cnt   = 8'h0;
            m_ovf   = 1'b0;
            started = 1'b1;
        end else begin
            was_full = (m_q.size() == DEPTH);
            xfer     = m_valid && ready;
            if (xfer) m_cnt = m_cnt + 8'd1;
            if ((!m_valid || xfer) && m_q.size() > 0) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            if (wr_en) begin
                if (was_full) m_ovf = 1'b1;
                else m_q.push_back(wr_data);
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("model valid", valid_o, m_valid);
            chk("model data", data_o, m_data);
            chk("model full", full_o, m_q.size() == DEPTH);
            chk("model empty", empty_o, (m_q.size() == 0) && !m_valid);
            chk("model sent_cnt", sent_cnt_o, m_cnt);
            chk("model overflow", overflow_o, m_ovf);
        end
    end

    task automatic step(input logic w, input logic [3:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        ready   = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 4'h0, 1'b0);
        rst = 1'b0;
    endtask

    logic [3:0] stall_exp [6];
    logic       stall_rdy [6];

    initial begin
        stall_exp = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h3, 4'h3};
        stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state and single word
        do_reset();
        chk("reset valid", valid_o, 1'b0);
        chk("reset empty", empty_o, 1'b1);
        chk("reset sent", sent_cnt_o, 8'd0);
        chk("reset full", full_o, 1'b0);
        step(1'b1, 4'hA, 1'b1);
        chk("single E0 valid", valid_o, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        chk("single E1 valid", valid_o, 1'b1);
        chk("single E1 data", data_o, 4'hA);
        step(1'b0, 4'h0, 1'b1);
        chk("single E2 valid", valid_o, 1'b0);
        chk("single E2 sent", sent_cnt_o, 8'd1);
        chk("single E2 empty", empty_o, 1'b1);

        // Back-pressure fill
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 4'(i), 1'b0);
        chk("fill valid", valid_o, 1'b1);
        chk("fill data", data_o, 4'h1);
        chk("fill full", full_o, 1'b1);
        chk("fill overflow", overflow_o, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            chk("drain valid", valid_o, 1'b1);
            chk("drain data", data_o, 4'(i));
            step(1'b0, 4'h0, 1'b1);
        end
        chk("drain end valid", valid_o, 1'b0);
        chk("drain end sent", sent_cnt_o, 8'd5);

        // Stall hold
        do_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("stall data", data_o, stall_exp[i]);
            step(1'b0, 4'h0, stall_rdy[i]);
        end
        chk("stall end valid", valid_o, 1'b0);
        chk("stall end sent", sent_cnt_o, 8'd3);

        // Full with simultaneous pop
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
        chk("fullpop pre full", full_o, 1'b1);
        chk("fullpop pre ovf", overflow_o, 1'b0);
        step(1'b1, 4'hF, 1'b1);
        chk("fullpop full", full_o, 1'b0);
        chk("fullpop ovf", overflow_o, 1'b1);
        chk("fullpop data", data_o, 4'h2);
        for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 1'b1);
        chk("fullpop sent", sent_cnt_o, 8'd5);
        chk("fullpop empty", empty_o, 1'b1);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 4'(i), 1'b1);
        step(1'b0, 4'h0, 1'b1);
        chk("wrap sent 255", sent_cnt_o, 8'd255);
        chk("wrap last data", data_o, 4'hF);
        step(1'b0, 4'h0, 1'b1);
        chk("wrap sent 0", sent_cnt_o, 8'd0);
        chk("wrap valid", valid_o, 1'b0);

        // Reset mid-stream
        do_reset();
        step(1'b1, 4'h9, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        for (int i = 1; i <= 6; i++) step(1'b1, 4'(i), 1'b0);
        chk("midrst pre valid", valid_o, 1'b1);
        chk("midrst pre ovf", overflow_o, 1'b1);
        rst = 1'b1;
        step(1'b1, 4'hC, 1'b1);
        rst = 1'b0;
        chk("midrst valid", valid_o, 1'b0);
        chk("midrst data", data_o, 4'h0);
        chk("midrst sent", sent_cnt_o, 8'd0);
        chk("midrst ovf", overflow_o, 1'b0);
        chk("midrst empty", empty_o, 1'b1);
        chk("midrst full", full_o, 1'b0);
        step(1'b1, 4'h7, 1'b0);
        chk("post rst E0 valid", valid_o, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        chk("post rst E1 valid", valid_o, 1'b1);
        chk("post rst E1 data", data_o, 4'h7);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
